// File: rtl/cpu_sram_axi_bridge_pkg.sv
// rtl/cpu_sram_axi_bridge_pkg.sv - shared types and constants for the SRAM-like to AXI bridge
package cpu_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] ID_INST_DEF = 4'd0;
    localparam logic [3:0] ID_DATA_DEF = 4'd1;

    // SRAM-like size codes map directly onto AXI size, just zero-extended
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cpu_sram_axi_bridge_req_arb.sv
// rtl/cpu_sram_axi_bridge_req_arb.sv - fixed-priority grant between data and inst ports
module bridge_req_arb
    import cpu_sram_axi_bridge_pkg::*;
(
    input  logic   en,
    input  logic   inst_req,
    input  logic   data_req,
    output logic   grant,
    output owner_e grant_owner,
    output logic   inst_addr_ok,
    output logic   data_addr_ok
);

    // Data port always wins; addr_ok only while the bridge can accept a request
    always_comb begin
        grant        = en && (data_req || inst_req);
        grant_owner  = data_req ? OWN_DATA : OWN_INST;
        data_addr_ok = en && data_req;
        inst_addr_ok = en && inst_req && !data_req;
    end

endmodule

// File: rtl/cpu_sram_axi_bridge.sv
// rtl/cpu_sram_axi_bridge.sv - two SRAM-like CPU ports onto one single-outstanding AXI master
module cpu_sram_axi_bridge
    import cpu_sram_axi_bridge_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] ID_INST = ID_INST_DEF,
    parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bvalid,
    output logic                bready
);

    state_e              state_q, state_d;
    owner_e              owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                aw_done_q, w_done_q;
    logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;
    logic                inst_ok_q, data_ok_q;

    logic                grant_en, grant;
    owner_e              grant_owner;
    logic                aw_fin, w_fin;
    logic                r_fire, b_fire;
    logic                unused_rid;

    // Single outstanding transaction, so the read ID carries no information
    assign unused_rid = ^rid;

    // No new request while a response pulse is out, so a port never sees addr_ok and data_ok together
    assign grant_en = (state_q == ST_IDLE) && !inst_ok_q && !data_ok_q;

    bridge_req_arb u_arb (
        .en           (grant_en),
        .inst_req     (inst_req),
        .data_req     (data_req),
        .grant        (grant),
        .grant_owner  (grant_owner),
        .inst_addr_ok (inst_addr_ok),
        .data_addr_ok (data_addr_ok)
    );

    // AXI channel controls decode straight from the registered state and done flags
    always_comb begin
        arvalid = (state_q == ST_AR);
        rready  = (state_q == ST_R);
        awvalid = (state_q == ST_AW_W) && !aw_done_q;
        wvalid  = (state_q == ST_AW_W) && !w_done_q;
        bready  = (state_q == ST_B);
        aw_fin  = aw_done_q || (awvalid && awready);
        w_fin   = w_done_q || (wvalid && wready);
        r_fire  = rready && rvalid;
        b_fire  = bready && bvalid;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = (grant_owner == OWN_DATA && data_wr) ? ST_AW_W : ST_AR;
            ST_AR:   if (arready) state_d = ST_R;
            ST_R:    if (rvalid) state_d = ST_IDLE;
            ST_AW_W: if (aw_fin && w_fin) state_d = ST_B;
            ST_B:    if (bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, request latch, handshake flags and response registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            addr_q       <= '0;
            size_q       <= SIZE_WORD;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_ok_q <= r_fire && (owner_q == OWN_INST);
            data_ok_q <= (r_fire && (owner_q == OWN_DATA)) || b_fire;
            if (grant) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_DATA) begin
                    addr_q  <= data_addr;
                    size_q  <= data_size;
                    wstrb_q <= data_wstrb;
                    wdata_q <= data_wdata;
                end else begin
                    addr_q  <= inst_addr;
                    size_q  <= SIZE_WORD;
                    wstrb_q <= '0;
                    wdata_q <= '0;
                end
            end
            if (state_q == ST_AW_W) begin
                aw_done_q <= aw_fin;
                w_done_q  <= w_fin;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (r_fire) begin
                if (owner_q == OWN_INST) inst_rdata_q <= rdata;
                else                     data_rdata_q <= rdata;
            end
        end
    end

    assign arid         = (owner_q == OWN_DATA) ? ID_DATA : ID_INST;
    assign araddr       = addr_q;
    assign arsize       = axi_size(size_q);
    assign awid         = ID_DATA;
    assign awaddr       = addr_q;
    assign awsize       = axi_size(size_q);
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// tb/tb_cpu_sram_axi_bridge.sv - directed self-checking bench for cpu_sram_axi_bridge
module tb_cpu_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, rid, awid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge; inputs are driven here and outputs sampled 1 time unit later
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 2;
        data_addr = 0; data_wstrb = 0; data_wdata = 0; arready = 0; rid = 0; rdata = 0;
        rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        cyc(); cyc();
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);

        // 1. inst read, zero-wait slave
        cyc(); resetn = 1; inst_req = 1; inst_addr = 32'h1c000000; arready = 1; #1;
        chk("t1_c0_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_c0_arvalid", arvalid, 0);
        cyc(); inst_req = 0; #1;
        chk("t1_c1_arvalid", arvalid, 1);
        chk("t1_c1_araddr", araddr, 32'h1c000000);
        chk("t1_c1_arid", arid, 0);
        chk("t1_c1_arsize", arsize, 2);
        chk("t1_c1_addr_ok", inst_addr_ok, 0);
        cyc(); rvalid = 1; rdata = 32'h02800c0c; #1;
        chk("t1_c2_rready", rready, 1);
        chk("t1_c2_arvalid", arvalid, 0);
        chk("t1_c2_data_ok", inst_data_ok, 0);
        cyc(); rvalid = 0; #1;
        chk("t1_c3_data_ok", inst_data_ok, 1);
        chk("t1_c3_rdata", inst_rdata, 32'h02800c0c);
        chk("t1_c3_rready", rready, 0);
        cyc(); #1;
        chk("t1_c4_data_ok", inst_data_ok, 0);

        // 2. simultaneous requests, data wins
        cyc(); inst_req = 1; inst_addr = 32'h1c000004; data_req = 1; data_wr = 0; data_addr = 32'h8000; #1;
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        cyc(); data_req = 0; #1;
        chk("t2_c1_arid", arid, 1);
        chk("t2_c1_araddr", araddr, 32'h8000);
        chk("t2_c1_inst_addr_ok", inst_addr_ok, 0);
        cyc(); rvalid = 1; rdata = 32'h11223344; #1;
        chk("t2_c2_inst_addr_ok", inst_addr_ok, 0);
        cyc(); rvalid = 0; #1;
        chk("t2_c3_data_ok", data_data_ok, 1);
        chk("t2_c3_data_rdata", data_rdata, 32'h11223344);
        chk("t2_c3_inst_addr_ok", inst_addr_ok, 0);
        chk("t2_c3_inst_rdata_kept", inst_rdata, 32'h02800c0c);
        cyc(); #1;
        chk("t2_c4_inst_addr_ok", inst_addr_ok, 1);
        chk("t2_c4_data_ok", data_data_ok, 0);
        cyc(); inst_req = 0; #1;
        chk("t2_c5_araddr", araddr, 32'h1c000004);
        chk("t2_c5_arid", arid, 0);
        cyc(); rvalid = 1; rdata = 32'h0000a5a5; #1;
        cyc(); rvalid = 0; #1;
        chk("t2_c7_inst_data_ok", inst_data_ok, 1);
        chk("t2_c7_inst_rdata", inst_rdata, 32'h0000a5a5);
        chk("t2_c7_data_data_ok", data_data_ok, 0);

        // 3. word write, awready one cycle before wready
        cyc(); data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8004;
        data_wdata = 32'hdeadbeef; data_wstrb = 4'hf; awready = 1; wready = 0; #1;
        chk("t3_c0_data_addr_ok", data_addr_ok, 1);
        cyc(); data_req = 0; #1;
        chk("t3_c1_awvalid", awvalid, 1);
        chk("t3_c1_wvalid", wvalid, 1);
        chk("t3_c1_awaddr", awaddr, 32'h8004);
        chk("t3_c1_wdata", wdata, 32'hdeadbeef);
        chk("t3_c1_wstrb", wstrb, 4'hf);
        chk("t3_c1_awid", awid, 1);
        chk("t3_c1_arvalid", arvalid, 0);
        cyc(); awready = 0; wready = 1; #1;
        chk("t3_c2_awvalid", awvalid, 0);
        chk("t3_c2_wvalid", wvalid, 1);
        chk("t3_c2_bready", bready, 0);
        cyc(); wready = 0; bvalid = 1; #1;
        chk("t3_c3_wvalid", wvalid, 0);
        chk("t3_c3_awvalid", awvalid, 0);
        chk("t3_c3_bready", bready, 1);
        chk("t3_c3_data_ok", data_data_ok, 0);
        cyc(); bvalid = 0; #1;
        chk("t3_c4_data_ok", data_data_ok, 1);
        chk("t3_c4_bready", bready, 0);
        cyc(); #1;
        chk("t3_c5_data_ok", data_data_ok, 0);

        // 4. arready stalled for 5 cycles, data request pending meanwhile
        cyc(); inst_req = 1; inst_addr = 32'h1c000100; arready = 0; #1;
        chk("t4_c0_inst_addr_ok", inst_addr_ok, 1);
        cyc(); inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h9000; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_stall%0d_arvalid", i), arvalid, 1);
            chk($sformatf("t4_stall%0d_araddr", i), araddr, 32'h1c000100);
            chk($sformatf("t4_stall%0d_addr_ok", i), {inst_addr_ok, data_addr_ok}, 0);
            cyc(); #1;
        end
        data_req = 0; arready = 1; #1;
        chk("t4_release_arvalid", arvalid, 1);
        chk("t4_release_araddr", araddr, 32'h1c000100);
        cyc(); rvalid = 1; rdata = 32'h12345678; #1;
        chk("t4_r_rready", rready, 1);
        cyc(); rvalid = 0; #1;
        chk("t4_inst_data_ok", inst_data_ok, 1);
        chk("t4_inst_rdata", inst_rdata, 32'h12345678);

        // 5. reset while in R aborts the read
        cyc(); inst_req = 1; inst_addr = 32'h1c000200; #1;
        chk("t5_c0_inst_addr_ok", inst_addr_ok, 1);
        cyc(); inst_req = 0; #1;
        cyc(); resetn = 0; #1;
        chk("t5_in_r_rready", rready, 1);
        cyc(); resetn = 1; #1;
        chk("t5_post_rready", rready, 0);
        chk("t5_post_arvalid", arvalid, 0);
        chk("t5_post_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("t5_post_inst_rdata", inst_rdata, 0);
        cyc(); #1;
        chk("t5_no_late_data_ok", inst_data_ok, 0);
        inst_req = 1; inst_addr = 32'h1c000300; #1;
        chk("t5_new_addr_ok", inst_addr_ok, 1);
        cyc(); inst_req = 0; #1;
        chk("t5_new_araddr", araddr, 32'h1c000300);
        cyc(); rvalid = 1; rdata = 32'h0badf00d; #1;
        cyc(); rvalid = 0; #1;
        chk("t5_new_data_ok", inst_data_ok, 1);
        chk("t5_new_rdata", inst_rdata, 32'h0badf00d);

        // 6. byte store, AW and W accepted together
        cyc(); data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8003;
        data_wstrb = 4'h8; data_wdata = 32'h44000000; awready = 1; wready = 1; #1;
        chk("t6_c0_data_addr_ok", data_addr_ok, 1);
        cyc(); data_req = 0; #1;
        chk("t6_awsize", awsize, 0);
        chk("t6_awaddr", awaddr, 32'h8003);
        chk("t6_wstrb", wstrb, 4'h8);
        chk("t6_both_valid", {awvalid, wvalid}, 2'b11);
        cyc(); awready = 0; wready = 0; bvalid = 1; #1;
        chk("t6_bready", bready, 1);
        chk("t6_valids_low", {awvalid, wvalid}, 0);
        cyc(); bvalid = 0; #1;
        chk("t6_data_ok", data_data_ok, 1);
        cyc(); #1;
        chk("t6_data_ok_end", data_data_ok, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
